sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Arbitrates a core port and a debug port onto one synchronous SRAM port.
//   The core has priority. A debug request that keeps losing is forced to win
//   once it has lost MAX_WAIT times in a row. Debug can also lock the SRAM for
//   its own exclusive use.
//   The SRAM address, write enable and write data are registered from the
//   winner. Read data comes back on the winner's rdata/rvalid two cycles after
//   the grant.
// Ports
//   clk, arst_n                     clock, asynchronous active-low reset
//   core_req/we/addr/wdata          core request (held stable until granted)
//   core_grant                      combinational accept for this edge
//   core_rdata, core_rvalid         core read return and one-cycle strobe
//   dbg_req/we/lock/addr/wdata      debug request, lock asks for exclusivity
//   dbg_grant, dbg_rdata, dbg_rvalid
//   sram_addr, sram_write_en, sram_data_out, sram_data_in   SRAM port
module sram_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       core_req,
    input  logic       core_we,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic       core_grant,
    output logic [7:0] core_rdata,
    output logic       core_rvalid,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic       dbg_lock,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_grant,
    output logic [7:0] dbg_rdata,
    output logic       dbg_rvalid,
    output logic [7:0] sram_addr,
    output logic       sram_write_en,
    output logic [7:0] sram_data_out,
    input  logic [7:0] sram_data_in
);

    typedef enum logic {SHARED = 1'b0, DBG_LOCKED = 1'b1} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic       we_q, we_d;
    // One read in flight at most: issued at the grant edge, captured at the next.
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;  // 1 = debug
    logic [7:0] core_rdata_q, core_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic       core_rvalid_q, core_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;

    // Grants are combinational. Gating them with arst_n keeps them low while
    // reset is held, without waiting for a clock edge.
    always_comb begin
        core_grant = 1'b0;
        dbg_grant  = 1'b0;
        if (arst_n) begin
            if (state_q == DBG_LOCKED) begin
                dbg_grant = dbg_req;
            end else if (dbg_req && (!core_req || wait_cnt_q == MAX_W)) begin
                dbg_grant = 1'b1;
            end else begin
                core_grant = core_req;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = 4'd0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = 1'b0;
        rd_pend_d     = 1'b0;
        rd_owner_d    = rd_owner_q;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        core_rvalid_d = 1'b0;
        dbg_rvalid_d  = 1'b0;

        case (state_q)
            SHARED: begin
                // A lock only takes effect once debug actually wins.
                if (dbg_grant && dbg_lock) state_d = DBG_LOCKED;
                if (dbg_req && !dbg_grant)
                    wait_cnt_d = (wait_cnt_q >= MAX_W) ? MAX_W : wait_cnt_q + 4'd1;
            end
            DBG_LOCKED: begin
                if (!dbg_lock) state_d = SHARED;
            end
            default: state_d = SHARED;
        endcase

        if (core_grant || dbg_grant) begin
            addr_d     = dbg_grant ? dbg_addr  : core_addr;
            wdata_d    = dbg_grant ? dbg_wdata : core_wdata;
            we_d       = dbg_grant ? dbg_we    : core_we;
            rd_pend_d  = !we_d;
            rd_owner_d = dbg_grant;
        end

        // The SRAM presents data for the previous edge's address. Route it to
        // the recorded owner only, so the other port's rdata is untouched.
        if (rd_pend_q) begin
            if (rd_owner_q) begin
                dbg_rdata_d  = sram_data_in;
                dbg_rvalid_d = 1'b1;
            end else begin
                core_rdata_d  = sram_data_in;
                core_rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= SHARED;
            wait_cnt_q    <= 4'd0;
            addr_q        <= 8'd0;
            wdata_q       <= 8'd0;
            we_q          <= 1'b0;
            rd_pend_q     <= 1'b0;
            rd_owner_q    <= 1'b0;
            core_rdata_q  <= 8'd0;
            dbg_rdata_q   <= 8'd0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            rd_pend_q     <= rd_pend_d;
            rd_owner_q    <= rd_owner_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
        end
    end

    assign sram_addr     = addr_q;
    assign sram_write_en = we_q;
    assign sram_data_out = wdata_q;
    assign core_rdata    = core_rdata_q;
    assign core_rvalid   = core_rvalid_q;
    assign dbg_rdata     = dbg_rdata_q;
    assign dbg_rvalid    = dbg_rvalid_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A transaction-level model tracks expected grants, the SRAM bus
//   and read returns. The bench's SRAM reads asynchronously and writes on the
//   clock edge.
module tb_sram_arbiter;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic       core_grant, core_rvalid, dbg_grant, dbg_rvalid, sram_write_en;
    logic [7:0] core_rdata, dbg_rdata, sram_addr, sram_data_out, sram_data_in;

    sram_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .arst_n(arst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_grant(core_grant),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_grant(dbg_grant),
        .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .sram_addr(sram_addr), .sram_write_en(sram_write_en),
        .sram_data_out(sram_data_out), .sram_data_in(sram_data_in)
    );

    always #5 clk = ~clk;

    // Bench SRAM
    logic [7:0] mem [256];
    assign sram_data_in = mem[sram_addr];
    always @(posedge clk) if (sram_write_en) mem[sram_addr] <= sram_data_out;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       dbg;
        bit [7:0] data;
        int       due;
    } ret_t;

    bit       m_locked;
    int       m_wait;
    int       cyc;
    bit       m_cg, m_dg;
    bit [7:0] ref_mem [256];
    bit [7:0] e_addr, e_dout, e_crd, e_drd;
    bit       e_we, e_crv, e_drv;
    ret_t     rq[$];

    // Grants are derived from the rules for the current cycle's inputs.
    // Inputs are stable between the drive point and the next rising edge.
    always @(negedge clk) begin
        if (arst_n) begin
            if (m_locked) begin
                m_dg = dbg_req;
                m_cg = 0;
            end else begin
                m_dg = dbg_req && (!core_req || m_wait == MAXW);
                m_cg = core_req && !m_dg;
            end
            chk1("core_grant", core_grant, m_cg);
            chk1("dbg_grant", dbg_grant, m_dg);
            chk8("sram_addr", sram_addr, e_addr);
            chk1("sram_write_en", sram_write_en, e_we);
            chk8("sram_data_out", sram_data_out, e_dout);
            chk1("core_rvalid", core_rvalid, e_crv);
            chk1("dbg_rvalid", dbg_rvalid, e_drv);
            chk8("core_rdata", core_rdata, e_crd);
            chk8("dbg_rdata", dbg_rdata, e_drd);
        end
    end

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_locked = 0; m_wait = 0; m_cg = 0; m_dg = 0;
            e_addr = 0; e_dout = 0; e_we = 0;
            e_crd = 0; e_drd = 0; e_crv = 0; e_drv = 0;
            rq.delete();
        end else begin
            cyc++;
            e_crv = 0;
            e_drv = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                ret_t r;
                r = rq.pop_front();
                if (r.dbg) begin e_drv = 1; e_drd = r.data; end
                else       begin e_crv = 1; e_crd = r.data; end
            end
            if (m_locked)                m_wait = 0;
            else if (dbg_req && !m_dg)   m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
            else                         m_wait = 0;
            m_locked = m_locked ? dbg_lock : (m_dg && dbg_lock);
            if (m_cg || m_dg) begin
                e_addr = m_dg ? dbg_addr  : core_addr;
                e_dout = m_dg ? dbg_wdata : core_wdata;
                e_we   = m_dg ? dbg_we    : core_we;
                // Accesses complete in grant order, so the memory can be
                // updated at the accept.
                if (e_we) ref_mem[e_addr] = e_dout;
                else      rq.push_back('{dbg: m_dg, data: ref_mem[e_addr], due: cyc + 1});
            end else begin
                e_we = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        core_req = 0; dbg_req = 0; dbg_lock = 0; core_we = 0; dbg_we = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_mem(input int a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    initial begin
        logic [9:0] cpat;
        arst_n = 0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0;
        cyc = 0;
        for (int i = 0; i < 256; i++) set_mem(i, 8'(i * 13 + 7));
        set_mem(8'h10, 8'hA5);
        set_mem(8'h01, 8'h11);
        set_mem(8'h02, 8'h22);

        // Reset state
        step();
        core_req = 1; dbg_req = 1;
        #2;
        chk1("rst core_grant", core_grant, 1'b0);
        chk1("rst dbg_grant", dbg_grant, 1'b0);
        chk8("rst sram_addr", sram_addr, 8'h00);
        chk1("rst sram_write_en", sram_write_en, 1'b0);
        core_req = 0; dbg_req = 0;
        step();
        arst_n = 1;

        // First grant right after reset release: core read of 0x10
        core_req = 1; core_we = 0; core_addr = 8'h10;
        #2 chk1("rd10 grant c0", core_grant, 1'b1);
        step();
        core_req = 0;
        #2 chk8("rd10 sram_addr c1", sram_addr, 8'h10);
        chk1("rd10 rvalid c1", core_rvalid, 1'b0);
        step();
        #2 chk1("rd10 rvalid c2", core_rvalid, 1'b1);
        chk8("rd10 rdata c2", core_rdata, 8'hA5);
        step();
        #2 chk1("rd10 rvalid c3", core_rvalid, 1'b0);
        idle(2);

        // Contention with requests held continuously
        core_req = 1; core_we = 0; core_addr = 8'h30;
        dbg_req = 1;  dbg_we = 0;  dbg_addr = 8'h31;
        for (int c = 0; c < 10; c++) begin
            #2;
            cpat[c] = core_grant;
            chk1("contend dbg_grant", dbg_grant, (c == 4 || c == 9));
            step();
        end
        chk8("contend core pattern", 8'(cpat[7:0]), 8'b1110_1111);
        chk8("contend core pattern hi", 8'(cpat[9:8]), 8'b01);
        idle(3);

        // Lock: debug write 0x3C -> 0x20 with lock, core waits
        dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 8'h20; dbg_wdata = 8'h3C;
        #2 chk1("lock dbg_grant", dbg_grant, 1'b1);
        step();
        dbg_req = 0;
        core_req = 1; core_we = 0; core_addr = 8'h21;
        for (int c = 1; c < 4; c++) begin
            #2 chk1("lock core held off", core_grant, 1'b0);
            step();
        end
        dbg_lock = 0;
        #2 chk1("lock core at unlock edge cycle", core_grant, 1'b0);
        step();
        #2 chk1("lock core after unlock", core_grant, 1'b1);
        step();
        core_req = 0;
        chk8("lock mem[0x20]", mem[8'h20], 8'h3C);
        idle(2);

        // Interleaved reads: core 0x01 then debug 0x02
        core_req = 1; core_we = 0; core_addr = 8'h01;
        step();
        core_req = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h02;
        #2 chk1("ilv dbg_grant", dbg_grant, 1'b1);
        step();
        dbg_req = 0;
        #2 chk1("ilv core_rvalid", core_rvalid, 1'b1);
        chk8("ilv core_rdata", core_rdata, 8'h11);
        chk1("ilv dbg_rvalid early", dbg_rvalid, 1'b0);
        step();
        #2 chk1("ilv dbg_rvalid", dbg_rvalid, 1'b1);
        chk8("ilv dbg_rdata", dbg_rdata, 8'h22);
        chk1("ilv core_rvalid late", core_rvalid, 1'b0);
        idle(2);

        // Write with no return
        core_req = 1; core_we = 1; core_addr = 8'h07; core_wdata = 8'h55;
        step();
        core_req = 0; core_we = 0;
        #2 chk1("wr sram_write_en", sram_write_en, 1'b1);
        chk8("wr sram_data_out", sram_data_out, 8'h55);
        chk8("wr sram_addr", sram_addr, 8'h07);
        for (int c = 0; c < 3; c++) begin
            step();
            #2 chk1("wr no core_rvalid", core_rvalid, 1'b0);
            chk1("wr we low", sram_write_en, 1'b0);
        end
        chk8("wr mem[0x07]", mem[8'h07], 8'h55);
        idle(2);

        // Reset in the cycle after a read grant
        core_req = 1; core_we = 0; core_addr = 8'h40;
        step();
        core_req = 0;
        arst_n = 0;
        #1;
        chk8("mid rst sram_addr", sram_addr, 8'h00);
        chk1("mid rst core_rvalid", core_rvalid, 1'b0);
        chk8("mid rst core_rdata", core_rdata, 8'h00);
        chk8("mid rst dbg_rdata", dbg_rdata, 8'h00);
        #2 arst_n = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            #2 chk1("post rst no core_rvalid", core_rvalid, 1'b0);
        end
        idle(2);

        // Randomized traffic; each requester holds its request until granted.
        for (int n = 0; n < 3000; n++) begin
            if (!core_req || m_cg) begin
                if ($urandom_range(0, 3) != 0) begin
                    core_req = 1; core_we = 1'($urandom_range(0, 1));
                    core_addr = 8'($urandom_range(0, 15)); core_wdata = 8'($urandom);
                end else core_req = 0;
            end
            if (!dbg_req || m_dg) begin
                if ($urandom_range(0, 2) != 0) begin
                    dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
                    dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 8'($urandom);
                end else dbg_req = 0;
            end
            if ($urandom_range(0, 7) == 0) dbg_lock = !dbg_lock;
            step();
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
